test_run_controller: RTL and testbench
======================================

TEST_RUN_CONTROLLER -- requirements
Module: test_run_controller

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of frame generators sequenced.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65536, ARM/STOPPING watchdog limit in clk cycles.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_start  input  1  request a timed run (level sampled each cycle).
REQ-006 SHALL have port cmd_abort  input  1  end current run early.
REQ-007 SHALL have port duration_cycles  input  32  run length in clk cycles, sampled at accepted cmd_start.
REQ-008 SHALL have port port_mask  input  NUM_PORTS  ports taking part, sampled at accepted cmd_start.
REQ-009 SHALL have port gen_ready  input  NUM_PORTS  per-generator idle indication.
REQ-010 SHALL have port gen_start  output  NUM_PORTS  per-generator one-cycle start pulse.
REQ-011 SHALL have port gen_stop  output  NUM_PORTS  per-generator one-cycle stop pulse.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at run end.
REQ-014 SHALL have port timeout_err  output  1  sticky flag, last run hit watchdog; cleared at next accepted start.
REQ-015 SHALL have port elapsed_cycles  output  32  RUN cycles counted in last/current run.

Function
REQ-016 SHALL implement states IDLE, ARM, RUN, STOPPING, DONE.
REQ-017 IDLE: cmd_start with latched mask nonzero SHALL be accepted -> ARM; mask, duration latched; elapsed_cycles and timeout_err cleared; watchdog cleared.
REQ-018 IDLE: cmd_start with port_mask==0 SHALL be ignored (stay IDLE, no outputs change).
REQ-019 duration_cycles==0 SHALL be latched as 1.
REQ-020 ARM: when (gen_ready & mask)==mask, SHALL drive gen_start=mask for exactly that cycle and go RUN next cycle.
REQ-021 ARM: watchdog increments each cycle not ready; on reaching TIMEOUT_CYCLES SHALL set timeout_err, go DONE, no gen_start issued.
REQ-022 ARM: cmd_abort SHALL go DONE without gen_start; abort wins over simultaneous readiness.
REQ-023 RUN: elapsed_cycles SHALL increment by 1 every cycle, first RUN cycle ends with value 1.
REQ-024 RUN: in the cycle elapsed_cycles+1 == latched duration, or cmd_abort high, SHALL drive gen_stop=mask for that cycle only, watchdog cleared, go STOPPING; elapsed_cycles includes that cycle.
REQ-025 STOPPING: SHALL wait for (gen_ready & mask)==mask, not sampled in the first STOPPING cycle; then go DONE.
REQ-026 STOPPING: watchdog reaching TIMEOUT_CYCLES SHALL set timeout_err and go DONE.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 cmd_start outside IDLE, cmd_abort in IDLE/STOPPING/DONE SHALL be ignored.
REQ-029 gen_start and gen_stop SHALL never be high for unmasked ports nor simultaneously.
REQ-030 elapsed_cycles SHALL hold its value after the run until next accepted start.
REQ-031 Port inputs changing mid-run SHALL not affect the run (latched copies only).

Reset
REQ-032 rst SHALL force IDLE, gen_start=0, gen_stop=0, busy=0, done=0, timeout_err=0, elapsed_cycles=0, latched mask/duration=0, watchdog=0, in the following cycle regardless of state.
REQ-033 rst asserted mid-RUN SHALL not emit gen_stop; generators are reset by the same rst.

Verification
REQ-034 mask=4'b0101, duration=10, gen_ready all 1, cmd_start 1 cycle -> gen_start=0101 one cycle, gen_stop=0101 exactly 10 cycles later, elapsed_cycles=10, done pulse after masked gen_ready return.
REQ-035 RUN with duration=1000, cmd_abort at RUN cycle 5 -> gen_stop same cycle, elapsed_cycles=5, timeout_err=0.
REQ-036 gen_ready[1]=0 held, mask=0010, TIMEOUT_CYCLES=16 -> no gen_start, timeout_err=1 and done after 16 ARM cycles.
REQ-037 Generator never returns ready after stop, TIMEOUT_CYCLES=16 -> timeout_err=1, done; next start clears timeout_err.
REQ-038 cmd_start with port_mask=0 -> busy stays 0; cmd_start during RUN -> no effect; duration=0 -> behaves as 1.
REQ-039 rst asserted in RUN cycle 3 -> next cycle all outputs 0, state IDLE, no gen_stop pulse.

Source files
------------

// File: rtl/test_run_controller.sv
// Test run sequencer: arms a set of frame generators, runs them for a latched
// number of cycles, stops them and reports completion or watchdog timeout.
module test_run_controller #(
    parameter int NUM_PORTS      = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_start,
    input  logic                 cmd_abort,
    input  logic [31:0]          duration_cycles,
    input  logic [NUM_PORTS-1:0] port_mask,
    input  logic [NUM_PORTS-1:0] gen_ready,
    output logic [NUM_PORTS-1:0] gen_start,
    output logic [NUM_PORTS-1:0] gen_stop,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic [31:0]          elapsed_cycles
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ARM, RUN, STOPPING, DONE} state_t;

    state_t               state;
    logic [NUM_PORTS-1:0] mask_q;
    logic [31:0]          dur_q;
    logic [WD_W-1:0]      wd;
    logic                 ready_all;

    assign ready_all = ((gen_ready & mask_q) == mask_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mask_q         <= '0;
            dur_q          <= '0;
            wd             <= '0;
            gen_start      <= '0;
            gen_stop       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout_err    <= 1'b0;
            elapsed_cycles <= '0;
        end else begin
            gen_start <= '0;
            gen_stop  <= '0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_start && (port_mask != '0)) begin
                        mask_q         <= port_mask;
                        dur_q          <= (duration_cycles == '0) ? 32'd1 : duration_cycles;
                        elapsed_cycles <= '0;
                        timeout_err    <= 1'b0;
                        wd             <= '0;
                        busy           <= 1'b1;
                        state          <= ARM;
                    end
                end
                ARM: begin
                    if (cmd_abort) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (ready_all) begin
                        gen_start <= mask_q;
                        state     <= RUN;
                    end else if (wd == WD_LAST) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RUN: begin
                    elapsed_cycles <= elapsed_cycles + 32'd1;
                    if ((elapsed_cycles + 32'd1 == dur_q) || cmd_abort) begin
                        gen_stop <= mask_q;
                        wd       <= '0;
                        state    <= STOPPING;
                    end
                end
                STOPPING: begin
                    // wd is zero only in the first STOPPING cycle, when generators
                    // have not yet seen the stop pulse
                    if ((wd != '0) && ready_all) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (wd == WD_LAST) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_run_controller.sv
// Directed self-checking bench for test_run_controller (TIMEOUT_CYCLES=16);
// outputs are sampled 1ns after each rising edge.
module tb_test_run_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start;
    logic        cmd_abort;
    logic [31:0] duration_cycles;
    logic [3:0]  port_mask;
    logic [3:0]  gen_ready;
    logic [3:0]  gen_start;
    logic [3:0]  gen_stop;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [31:0] elapsed_cycles;

    int tests = 0;
    int failures = 0;

    test_run_controller #(
        .NUM_PORTS(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_start(cmd_start),
        .cmd_abort(cmd_abort),
        .duration_cycles(duration_cycles),
        .port_mask(port_mask),
        .gen_ready(gen_ready),
        .gen_start(gen_start),
        .gen_stop(gen_stop),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err),
        .elapsed_cycles(elapsed_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        logic bad;

        rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0;
        duration_cycles = '0; port_mask = '0; gen_ready = 4'b1111;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", {22'd0, gen_start, gen_stop, done, timeout_err}, 32'd0);
        check("rst_elapsed", elapsed_cycles, 32'd0);
        rst = 1'b0;
        tick();

        // Basic timed run, mask 0101, duration 10
        port_mask = 4'b0101; duration_cycles = 32'd10; cmd_start = 1'b1;
        tick();
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_no_start", 32'(gen_start), 32'd0);
        cmd_start = 1'b0;
        tick();
        check("start_pulse", 32'(gen_start), 32'h5);
        port_mask = 4'b1111; duration_cycles = 32'd3; cmd_start = 1'b1;
        n = 0; bad = 1'b0;
        while (gen_stop == '0 && n < 50) begin
            tick();
            n++;
            if (n == 3) cmd_start = 1'b0;
            if (gen_start != '0) bad = 1'b1;
        end
        check("stop_latency", n, 32'd10);
        check("start_one_cycle", 32'(bad), 32'd0);
        check("stop_mask_latched", 32'(gen_stop), 32'h5);
        check("elapsed_10", elapsed_cycles, 32'd10);
        gen_ready = 4'b1010;
        tick();
        check("stop_one_cycle", 32'(gen_stop), 32'd0);
        tick(); tick();
        check("stop_wait", {30'd0, busy, done}, 32'h2);
        gen_ready = 4'b0101;
        tick();
        check("done_pulse", 32'(done), 32'd1);
        check("done_no_to", 32'(timeout_err), 32'd0);
        tick();
        check("idle_after_done", {30'd0, busy, done}, 32'd0);
        check("elapsed_hold", elapsed_cycles, 32'd10);

        // Abort in RUN cycle 5
        gen_ready = 4'b1111; port_mask = 4'b0011; duration_cycles = 32'd1000; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        tick();
        check("abort_run_start", 32'(gen_start), 32'h3);
        tick(); tick(); tick(); tick();
        check("abort_pre_stop", 32'(gen_stop), 32'd0);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check("abort_stop", 32'(gen_stop), 32'h3);
        check("abort_elapsed", elapsed_cycles, 32'd5);
        tick(); tick();
        check("abort_done", {30'd0, done, timeout_err}, 32'h2);
        tick();

        // ARM watchdog: port 1 never ready
        gen_ready = 4'b1101; port_mask = 4'b0010; duration_cycles = 32'd5; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (gen_start != '0) bad = 1'b1;
        end
        check("arm_to_wait", {30'd0, busy, done}, 32'h2);
        tick();
        if (gen_start != '0) bad = 1'b1;
        check("arm_no_gen_start", 32'(bad), 32'd0);
        check("arm_to_done", {30'd0, done, timeout_err}, 32'h3);
        tick();
        check("to_sticky", {30'd0, busy, timeout_err}, 32'h1);
        check("arm_to_elapsed", elapsed_cycles, 32'd0);

        // STOPPING watchdog: generator never returns ready
        gen_ready = 4'b1111; port_mask = 4'b0001; duration_cycles = 32'd2; cmd_start = 1'b1;
        tick();
        check("to_cleared_on_start", 32'(timeout_err), 32'd0);
        cmd_start = 1'b0;
        tick();
        check("st_to_start", 32'(gen_start), 32'h1);
        gen_ready = 4'b0000;
        tick(); tick();
        check("st_to_stop", 32'(gen_stop), 32'h1);
        for (int i = 0; i < 15; i++) tick();
        check("st_to_wait", {30'd0, busy, done}, 32'h2);
        tick();
        check("st_to_done", {30'd0, done, timeout_err}, 32'h3);
        tick();

        // duration 0 behaves as 1; this start also clears timeout_err
        gen_ready = 4'b1111; duration_cycles = 32'd0; cmd_start = 1'b1;
        tick();
        check("dur0_to_clear", 32'(timeout_err), 32'd0);
        cmd_start = 1'b0;
        tick(); tick();
        check("dur0_stop", 32'(gen_stop), 32'h1);
        check("dur0_elapsed", elapsed_cycles, 32'd1);
        tick(); tick();
        check("dur0_done", 32'(done), 32'd1);
        tick();

        // Zero mask start and abort in IDLE are ignored
        port_mask = 4'b0000; duration_cycles = 32'd4; cmd_start = 1'b1; cmd_abort = 1'b1;
        tick(); tick();
        cmd_start = 1'b0; cmd_abort = 1'b0;
        check("mask0_ignored", {30'd0, busy, done}, 32'd0);
        check("mask0_elapsed", elapsed_cycles, 32'd1);

        // Abort in ARM wins over readiness
        port_mask = 4'b1000; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0; cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check("arm_abort_done", {26'd0, gen_start, busy, done}, 32'h3);
        tick();

        // Reset in RUN cycle 3
        port_mask = 4'b0100; duration_cycles = 32'd100; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        tick(); tick(); tick();
        check("pre_rst_elapsed", elapsed_cycles, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_run_outs", {22'd0, gen_start, gen_stop, busy, done}, 32'd0);
        check("rst_run_elapsed", elapsed_cycles, 32'd0);
        tick();
        check("rst_run_no_stop", {26'd0, gen_stop, busy, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
